bus_addr_dec_n: RTL and testbench

//  Parametrised, registered bus address decoder for the bus top level.
//  - Decodes the upper SEL_W address bits into one-hot selects for NUM_S slaves.
//  - Holds the decoded select and the latched offset for the whole transfer.
//  - Flags unmapped accesses with a one-cycle decode error and keeps a saturating error count.
//  - Sits between the bus master/arbiter and the slave select/mux logic.

---
 rtl/bus_addr_dec_n_if.sv | 29 ++
 rtl/bus_addr_dec_n.sv | 106 ++++++++++
 tb/tb_bus_addr_dec_n.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_addr_dec_n_if.sv
// Bus between the master/arbiter and the address decoder: request/address in,
// registered slave select, latched offset and decode-error status out.
interface bus_addr_dec_n_if #(
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 3,
    parameter int NUM_S  = 2
);
    // Handshake: M_req is held high for the whole transfer. The address is taken
    // only on the edge that sees M_req high while the decoder is idle. Dropping
    // M_req ends the transfer. The decoder never stalls the master; busy reports
    // that a transfer or an error hold is still in progress.
    logic                    M_req;
    logic [ADDR_W-1:0]       M_addr;
    logic [NUM_S-1:0]        S_sel;
    logic [ADDR_W-SEL_W-1:0] S_offset;
    logic                    busy;
    logic                    dec_err;
    logic [7:0]              err_cnt;

    modport master (
        output M_req, M_addr,
        input  S_sel, S_offset, busy, dec_err, err_cnt
    );

    modport slave (
        input  M_req, M_addr,
        output S_sel, S_offset, busy, dec_err, err_cnt
    );
endinterface

// File: rtl/bus_addr_dec_n.sv
// Registered bus address decoder: the upper SEL_W address bits select one of NUM_S
// slaves. Unmapped regions raise a one-cycle dec_err and bump a saturating counter.
module bus_addr_dec_n #(
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 3,
    parameter int NUM_S  = 2
) (
    input  logic                clk,
    input  logic                reset,
    bus_addr_dec_n_if.slave     bus,
    output logic [1:0]          dbg_state
);
    localparam int OFF_W = ADDR_W - SEL_W;
    localparam logic [NUM_S-1:0] SEL_ONE = NUM_S'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        ERROR    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_S-1:0]   sel_q, sel_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [SEL_W-1:0]   idx;
    logic               mapped;

    assign idx    = bus.M_addr[ADDR_W-1 -: SEL_W];
    assign mapped = ({{(32-SEL_W){1'b0}}, idx} < $unsigned(NUM_S));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            off_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is the registered image of its next value. Anything not
    // explicitly held or loaded falls back to its idle value.
    always_comb begin
        state_d = state_q;
        sel_d   = '0;
        off_d   = '0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.M_req) begin
                    busy_d = 1'b1;
                    if (mapped) begin
                        state_d = ACTIVE;
                        sel_d   = SEL_ONE << idx;
                        off_d   = bus.M_addr[OFF_W-1:0];
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ACTIVE: begin
                // Address is deliberately ignored here: no re-decode mid-transfer.
                if (bus.M_req) begin
                    sel_d  = sel_q;
                    off_d  = off_q;
                    busy_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                state_d = bus.M_req ? WAIT_REL : IDLE;
                busy_d  = bus.M_req;
            end
            WAIT_REL: begin
                if (bus.M_req) busy_d = 1'b1;
                else           state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.S_sel    = sel_q;
    assign bus.S_offset = off_q;
    assign bus.busy     = busy_q;
    assign bus.dec_err  = err_q;
    assign bus.err_cnt  = cnt_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_bus_addr_dec_n.sv
// Bench for bus_addr_dec_n: a 2-slave and an 8-slave decoder share the same inputs
// and are checked with directed scenarios and a random run against a reference model.
module tb_bus_addr_dec_n;
    logic       clk;
    logic       reset;
    logic       req;
    logic [7:0] addr;
    logic [1:0] dbg_a, dbg_b;

    int checks   = 0;
    int failures = 0;

    bus_addr_dec_n_if #(.ADDR_W(8), .SEL_W(3), .NUM_S(2)) bus_a ();
    bus_addr_dec_n_if #(.ADDR_W(8), .SEL_W(3), .NUM_S(8)) bus_b ();

    assign bus_a.M_req  = req;
    assign bus_a.M_addr = addr;
    assign bus_b.M_req  = req;
    assign bus_b.M_addr = addr;

    bus_addr_dec_n #(.ADDR_W(8), .SEL_W(3), .NUM_S(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .dbg_state(dbg_a)
    );
    bus_addr_dec_n #(.ADDR_W(8), .SEL_W(3), .NUM_S(8)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .dbg_state(dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, one entry per DUT. kind: 0 no transfer, 1 mapped transfer,
    // 2 unmapped request waiting for M_req to drop.
    int         m_n[2] = '{2, 8};
    int         m_kind[2];
    logic [7:0] m_sel[2];
    logic [4:0] m_off[2];
    logic       m_busy[2];
    logic       m_err[2];
    logic [7:0] m_cnt[2];

    task automatic model_step();
        int idx;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_kind[k] = 0; m_sel[k] = 0; m_off[k] = 0;
                m_busy[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
            end else if (m_kind[k] == 0) begin
                m_sel[k] = 0; m_off[k] = 0; m_busy[k] = 0; m_err[k] = 0;
                if (req) begin
                    idx = int'(addr) / 32;
                    m_busy[k] = 1;
                    if (idx < m_n[k]) begin
                        m_kind[k] = 1;
                        m_sel[k]  = 8'(1 << idx);
                        m_off[k]  = 5'(int'(addr) % 32);
                    end else begin
                        m_kind[k] = 2;
                        m_err[k]  = 1;
                        m_cnt[k]  = (m_cnt[k] == 8'd255) ? 8'd255 : m_cnt[k] + 8'd1;
                    end
                end
            end else if (m_kind[k] == 1) begin
                if (!req) begin
                    m_kind[k] = 0; m_sel[k] = 0; m_off[k] = 0; m_busy[k] = 0;
                end
            end else begin
                m_err[k]  = 0;
                m_busy[k] = req;
                if (!req) m_kind[k] = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; addr = 8'h00;
        tick(); tick();
        checks++;
        if ({bus_a.S_sel, bus_a.S_offset, bus_a.busy, bus_a.dec_err, bus_a.err_cnt} !== 17'd0) begin
            failures++;
            $display("FAIL reset_a: got sel=%b off=%h busy=%b err=%b cnt=%0d, want all zero",
                     bus_a.S_sel, bus_a.S_offset, bus_a.busy, bus_a.dec_err, bus_a.err_cnt);
        end
        checks++;
        if ({bus_b.S_sel, bus_b.busy, bus_b.err_cnt} !== 17'd0) begin
            failures++;
            $display("FAIL reset_b: got sel=%h busy=%b cnt=%0d, want all zero",
                     bus_b.S_sel, bus_b.busy, bus_b.err_cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_active();
        addr = 8'hE0; req = 1'b1; tick();
        req = 1'b0; tick();
        checks++;
        if (bus_a.err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL pre_reset_cnt: got %0d want 1", bus_a.err_cnt);
        end
        addr = 8'h3A; req = 1'b1; tick(); tick();
        checks++;
        if (bus_a.S_sel !== 2'b10 || bus_a.busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_sel: got sel=%b busy=%b want 10/1", bus_a.S_sel, bus_a.busy);
        end
        reset = 1'b1; tick();
        checks++;
        if (bus_a.S_sel !== 2'b00 || bus_a.busy !== 1'b0 || bus_a.err_cnt !== 8'd0 ||
            bus_a.dec_err !== 1'b0 || bus_a.S_offset !== 5'h00) begin
            failures++;
            $display("FAIL reset_mid_active: got sel=%b busy=%b cnt=%0d off=%h want 00/0/0/00",
                     bus_a.S_sel, bus_a.busy, bus_a.err_cnt, bus_a.S_offset);
        end
        reset = 1'b0; req = 1'b0; tick();
    endtask

    task automatic test_hold();
        addr = 8'h15; req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus_a.S_sel !== 2'b01 || bus_a.S_offset !== 5'h15 || bus_a.busy !== 1'b1) begin
                failures++;
                $display("FAIL hold_cycle%0d: got sel=%b off=%h busy=%b want 01/15/1",
                         i, bus_a.S_sel, bus_a.S_offset, bus_a.busy);
            end
        end
        req = 1'b0; tick();
        checks++;
        if (bus_a.S_sel !== 2'b00 || bus_a.busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: got sel=%b busy=%b want 00/0", bus_a.S_sel, bus_a.busy);
        end
        tick();
    endtask

    task automatic test_no_redecode();
        addr = 8'h3A; req = 1'b1; tick();
        addr = 8'h05;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus_a.S_sel !== 2'b10 || bus_a.S_offset !== 5'h1A) begin
                failures++;
                $display("FAIL no_redecode%0d: got sel=%b off=%h want 10/1a",
                         i, bus_a.S_sel, bus_a.S_offset);
            end
            tick();
        end
        req = 1'b0; tick();
        checks++;
        if (bus_a.S_sel !== 2'b00) begin
            failures++;
            $display("FAIL no_redecode_release: got sel=%b want 00", bus_a.S_sel);
        end
    endtask

    task automatic test_unmapped();
        reset = 1'b1; req = 1'b0; tick();
        reset = 1'b0; tick();
        addr = 8'hE0; req = 1'b1; tick();
        checks++;
        if (bus_a.dec_err !== 1'b1 || bus_a.S_sel !== 2'b00 || bus_a.busy !== 1'b1 ||
            bus_a.err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL unmapped_first: got err=%b sel=%b busy=%b cnt=%0d want 1/00/1/1",
                     bus_a.dec_err, bus_a.S_sel, bus_a.busy, bus_a.err_cnt);
        end
        checks++;
        if (bus_b.S_sel !== 8'h80 || bus_b.dec_err !== 1'b0) begin
            failures++;
            $display("FAIL full_map_e0: got sel=%h err=%b want 80/0", bus_b.S_sel, bus_b.dec_err);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus_a.dec_err !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.S_sel !== 2'b00 ||
                bus_a.err_cnt !== 8'd1) begin
                failures++;
                $display("FAIL unmapped_hold%0d: got err=%b busy=%b sel=%b cnt=%0d want 0/1/00/1",
                         i, bus_a.dec_err, bus_a.busy, bus_a.S_sel, bus_a.err_cnt);
            end
        end
        req = 1'b0; tick();
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.err_cnt !== 8'd1 || bus_b.S_sel !== 8'h00) begin
            failures++;
            $display("FAIL unmapped_release: got busy=%b cnt=%0d selb=%h want 0/1/00",
                     bus_a.busy, bus_a.err_cnt, bus_b.S_sel);
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        reset = 1'b1; req = 1'b0; tick();
        reset = 1'b0; tick();
        for (int i = 0; i < 300; i++) begin
            addr = {3'($urandom_range(2, 7)), 5'($urandom)};
            req = 1'b1; tick();
            if (bus_a.dec_err === 1'b1) pulses++;
            req = 1'b0; tick();
            if (bus_a.dec_err === 1'b1) pulses++;
            if (i == 254 || i == 299) begin
                checks++;
                if (bus_a.err_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL saturate_at%0d: got cnt=%0d want 255", i + 1, bus_a.err_cnt);
                end
            end
        end
        checks++;
        if (pulses != 300) begin
            failures++;
            $display("FAIL saturate_pulses: got %0d want 300", pulses);
        end
        checks++;
        if (bus_b.err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL full_map_cnt: got %0d want 0", bus_b.err_cnt);
        end
    endtask

    task automatic test_random();
        logic [16:0] act_a, exp_a;
        logic [22:0] act_b, exp_b;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            req   = ($urandom_range(0, 2) != 0);
            addr  = 8'($urandom);
            tick();
            act_a = {bus_a.S_sel, bus_a.S_offset, bus_a.busy, bus_a.dec_err, bus_a.err_cnt};
            exp_a = {m_sel[0][1:0], m_off[0], m_busy[0], m_err[0], m_cnt[0]};
            act_b = {bus_b.S_sel, bus_b.S_offset, bus_b.busy, bus_b.dec_err, bus_b.err_cnt};
            exp_b = {m_sel[1], m_off[1], m_busy[1], m_err[1], m_cnt[1]};
            checks++;
            if (act_a !== exp_a) begin
                failures++;
                $display("FAIL random_a cyc=%0d: got {sel,off,busy,err,cnt}=%h want %h", i, act_a, exp_a);
            end
            checks++;
            if (act_b !== exp_b) begin
                failures++;
                $display("FAIL random_b cyc=%0d: got {sel,off,busy,err,cnt}=%h want %h", i, act_b, exp_b);
            end
            checks++;
            if ($countones(bus_b.S_sel) > 1) begin
                failures++;
                $display("FAIL onehot_b cyc=%0d: got sel=%h want at most one bit", i, bus_b.S_sel);
            end
        end
        reset = 1'b0; req = 1'b0; tick();
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        addr  = 8'h00;
        test_reset();
        test_reset_mid_active();
        test_hold();
        test_no_redecode();
        test_unmapped();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
